// File: rtl/packet_framer.sv
// -----------------------------------------------------------------------------
// packet_framer
//
// Snapshots {header, payload, footer} on a capture strobe and streams the frame
// MSB first as bytes over a valid/ready handshake. In hex mode every nibble is
// sent as an uppercase ASCII character and the frame ends with CR LF. In binary
// mode raw bytes are sent. An optional 8-bit XOR checksum of the raw bytes
// follows the data (one byte in binary, two hex characters in hex mode).
//
// Ports
//   sysclk      in   single clock, rising edge
//   reset       in   asynchronous, active-high
//   capture     in   snapshot request, sampled every cycle
//   header      in   HEADER_WIDTH  header field
//   payload     in   PAYLOAD_WIDTH payload field
//   footer      in   FOOTER_WIDTH  footer field
//   tx_data     out  8   current symbol (0x00 when idle)
//   tx_valid    out  1   tx_data holds a symbol
//   tx_ready    in   1   sink accepts the symbol
//   busy        out  1   a frame is in flight
//   frame_done  out  1   one-cycle pulse after the last symbol transfers
//   overrun     out  1   capture seen while busy (request dropped)
// -----------------------------------------------------------------------------
module packet_framer #(
    parameter int PAYLOAD_WIDTH = 96,
    parameter int HEADER_WIDTH  = 64,
    parameter int FOOTER_WIDTH  = 64,
    parameter int BINARY        = 0,
    parameter int HAS_CHECKSUM  = 1
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     capture,
    input  logic [HEADER_WIDTH-1:0]  header,
    input  logic [PAYLOAD_WIDTH-1:0] payload,
    input  logic [FOOTER_WIDTH-1:0]  footer,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);

    localparam int W         = HEADER_WIDTH + PAYLOAD_WIDTH + FOOTER_WIDTH;
    localparam bit IS_BIN    = (BINARY != 0);
    localparam bit HAS_CS    = (HAS_CHECKSUM != 0);
    localparam int DATA_SYMS = IS_BIN ? W / 8 : W / 4;
    localparam int CNT_W     = $clog2(W / 4 + 5);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_SYMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CSUM = 2'd2,
        TERM = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     shadow;
    logic [7:0]       csum;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             last_sym;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // The symbol on tx_data is decoded from registered state only, so it is
    // stable for as long as the sink stalls.
    always_comb begin
        state_nxt = state;
        tx_data   = 8'h00;
        tx_valid  = (state != IDLE);
        xfer      = tx_valid && tx_ready;
        last_sym  = 1'b0;
        case (state)
            IDLE: begin
                if (capture)
                    state_nxt = DATA;
            end
            DATA: begin
                // The shadow shifts left on every transfer, so the current
                // symbol always sits at the top.
                tx_data  = IS_BIN ? shadow[W-1 -: 8] : hex_char(shadow[W-1 -: 4]);
                last_sym = (cnt == DATA_LAST);
                if (xfer && last_sym) begin
                    if (HAS_CS)
                        state_nxt = CSUM;
                    else if (!IS_BIN)
                        state_nxt = TERM;
                    else
                        state_nxt = IDLE;
                end
            end
            CSUM: begin
                if (IS_BIN)
                    tx_data = csum;
                else
                    tx_data = cnt[0] ? hex_char(csum[3:0]) : hex_char(csum[7:4]);
                last_sym = IS_BIN ? 1'b1 : cnt[0];
                if (xfer && last_sym)
                    state_nxt = IS_BIN ? IDLE : TERM;
            end
            TERM: begin
                tx_data  = cnt[0] ? 8'h0A : 8'h0D;
                last_sym = cnt[0];
                if (xfer && last_sym)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = tx_valid;
    assign overrun = capture && busy;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            csum       <= 8'h00;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= xfer && (state_nxt == IDLE);
            if (state == IDLE) begin
                if (capture) begin
                    shadow <= {header, payload, footer};
                    csum   <= 8'h00;
                    cnt    <= '0;
                end
            end else if (xfer) begin
                // Counter restarts at each state change so CSUM/TERM index
                // their own symbols from zero.
                if (state_nxt != state)
                    cnt <= '0;
                else
                    cnt <= cnt + CNT_W'(1);
                if (state == DATA) begin
                    if (IS_BIN) begin
                        csum   <= csum ^ shadow[W-1 -: 8];
                        shadow <= shadow << 8;
                    end else begin
                        // The whole raw byte is still at the top while its
                        // high nibble is being sent.
                        if (!cnt[0])
                            csum <= csum ^ shadow[W-1 -: 8];
                        shadow <= shadow << 4;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_framer.sv
module tb_packet_framer;

    logic        sysclk;
    logic        reset;
    logic        cap;
    logic        cap3;
    logic        rdy;
    logic        bp;
    logic [7:0]  hdr;
    logic [15:0] pay;
    logic [7:0]  ftr;
    logic [63:0] h3;
    logic [95:0] p3;
    logic [63:0] f3;

    logic [7:0]  dat [3];
    logic        vld [3];
    logic        bsy [3];
    logic        fd  [3];
    logic        ovr [3];

    int checks   = 0;
    int failures = 0;

    logic [8:0] qh[$];
    logic [8:0] qb[$];
    logic [8:0] q3[$];

    int   dcount [3] = '{0, 0, 0};
    int   xcount [3] = '{0, 0, 0};
    logic done_exp [3] = '{1'b0, 1'b0, 1'b0};
    logic stall [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] held [3];
    string nm [3] = '{"hex", "bin", "def"};

    logic [7:0] hex1 [12] = '{8'h41, 8'h35, 8'h31, 8'h32, 8'h33, 8'h34,
                              8'h30, 8'h46, 8'h38, 8'h43, 8'h0D, 8'h0A};
    logic [7:0] bin1 [5]  = '{8'hA5, 8'h12, 8'h34, 8'h0F, 8'h8C};
    logic [7:0] hex2 [12] = '{8'h33, 8'h43, 8'h30, 8'h30, 8'h46, 8'h46,
                              8'h38, 8'h31, 8'h34, 8'h32, 8'h0D, 8'h0A};
    logic [7:0] bin2 [5]  = '{8'h3C, 8'h00, 8'hFF, 8'h81, 8'h42};

    packet_framer #(.PAYLOAD_WIDTH(16), .HEADER_WIDTH(8), .FOOTER_WIDTH(8),
                    .BINARY(0), .HAS_CHECKSUM(1)) u_hex (
        .sysclk(sysclk), .reset(reset), .capture(cap),
        .header(hdr), .payload(pay), .footer(ftr),
        .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy),
        .busy(bsy[0]), .frame_done(fd[0]), .overrun(ovr[0]));

    packet_framer #(.PAYLOAD_WIDTH(16), .HEADER_WIDTH(8), .FOOTER_WIDTH(8),
                    .BINARY(1), .HAS_CHECKSUM(1)) u_bin (
        .sysclk(sysclk), .reset(reset), .capture(cap),
        .header(hdr), .payload(pay), .footer(ftr),
        .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy),
        .busy(bsy[1]), .frame_done(fd[1]), .overrun(ovr[1]));

    packet_framer #(.PAYLOAD_WIDTH(96), .HEADER_WIDTH(64), .FOOTER_WIDTH(64),
                    .BINARY(0), .HAS_CHECKSUM(0)) u_def (
        .sysclk(sysclk), .reset(reset), .capture(cap3),
        .header(h3), .payload(p3), .footer(f3),
        .tx_data(dat[2]), .tx_valid(vld[2]), .tx_ready(rdy),
        .busy(bsy[2]), .frame_done(fd[2]), .overrun(ovr[2]));

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pop_exp(input int k, output logic [8:0] e);
        e = '0;
        case (k)
            0: if (qh.size() != 0) begin e = qh.pop_front(); return 1'b1; end
            1: if (qb.size() != 0) begin e = qb.pop_front(); return 1'b1; end
            default: if (q3.size() != 0) begin e = q3.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    function automatic logic [7:0] asc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    // Ready driver: full throughput unless back-pressure mode is on, in which
    // case each accepted symbol is followed by a 0..5 cycle stall.
    initial begin
        int stall_left = 0;
        rdy = 1'b1;
        forever begin
            @(posedge sysclk);
            #1;
            if (bp) begin
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else begin
                    rdy = 1'b1;
                    stall_left = $urandom_range(0, 5);
                end
            end else begin
                rdy = 1'b1;
            end
        end
    end

    // Monitor: pops the expected symbol on every transfer, checks frame_done
    // after each last symbol and data stability during stalls.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge sysclk);
            for (int k = 0; k < 3; k++) begin
                if (reset) begin
                    done_exp[k] = 1'b0;
                    stall[k]    = 1'b0;
                end else begin
                    if (done_exp[k] || fd[k]) begin
                        check({nm[k], "_frame_done"}, 32'(fd[k]), 32'(done_exp[k]));
                        if (done_exp[k]) begin
                            check({nm[k], "_busy_end"}, 32'(bsy[k]), 32'd0);
                            check({nm[k], "_valid_end"}, 32'(vld[k]), 32'd0);
                        end
                    end
                    if (fd[k]) dcount[k]++;
                    done_exp[k] = 1'b0;
                    if (stall[k]) begin
                        check({nm[k], "_stall_data"}, 32'(dat[k]), 32'(held[k]));
                        check({nm[k], "_stall_valid"}, 32'(vld[k]), 32'd1);
                    end
                    if (vld[k] && rdy) begin
                        xcount[k]++;
                        checks++;
                        if (!pop_exp(k, e)) begin
                            failures++;
                            $display("FAIL %s_extra_symbol actual=%0h required=none", nm[k], dat[k]);
                        end else begin
                            if (dat[k] !== e[7:0]) begin
                                failures++;
                                $display("FAIL %s_symbol actual=%0h required=%0h t=%0t",
                                         nm[k], dat[k], e[7:0], $time);
                            end
                            done_exp[k] = e[8];
                        end
                    end
                    stall[k] = vld[k] && !rdy;
                    held[k]  = dat[k];
                end
            end
        end
    end

    task automatic pulse(input bit def);
        @(posedge sysclk); #1;
        if (def) cap3 = 1'b1; else cap = 1'b1;
        @(posedge sysclk); #1;
        if (def) cap3 = 1'b0; else cap = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(qh.size() == 0 && qb.size() == 0 && q3.size() == 0 &&
                 !bsy[0] && !bsy[1] && !bsy[2]) && n < 2000) begin
            @(negedge sysclk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d cycles required=<2000 left=%0d/%0d/%0d",
                     name, n, qh.size(), qb.size(), q3.size());
        end
        @(negedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic push_small(input bit second);
        for (int i = 0; i < 12; i++)
            qh.push_back({i == 11, second ? hex2[i] : hex1[i]});
        for (int i = 0; i < 5; i++)
            qb.push_back({i == 4, second ? bin2[i] : bin1[i]});
    endtask

    task automatic set_small(input bit second);
        if (second) begin hdr = 8'h3C; pay = 16'h00FF; ftr = 8'h81; end
        else        begin hdr = 8'hA5; pay = 16'h1234; ftr = 8'h0F; end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int nh;
        int nb;
        logic [223:0] fv;
        reset = 1'b1;
        cap   = 1'b0;
        cap3  = 1'b0;
        bp    = 1'b0;
        set_small(1'b0);
        h3 = 64'h0123_4567_89AB_CDEF;
        p3 = 96'hFEDC_BA98_7654_3210_0F1E_2D3C;
        f3 = 64'hDEAD_BEEF_CAFE_F00D;

        repeat (2) @(negedge sysclk);
        for (int k = 0; k < 3; k++) begin
            check({nm[k], "_rst_data"},  32'(dat[k]), 32'd0);
            check({nm[k], "_rst_valid"}, 32'(vld[k]), 32'd0);
            check({nm[k], "_rst_busy"},  32'(bsy[k]), 32'd0);
            check({nm[k], "_rst_done"},  32'(fd[k]),  32'd0);
            check({nm[k], "_rst_ovr"},   32'(ovr[k]), 32'd0);
        end
        @(posedge sysclk); #1;
        reset = 1'b0;

        // Hex and binary frames at full rate, then a back-to-back capture in
        // the hex frame_done cycle.
        push_small(1'b0);
        pulse(1'b0);
        check("hex_latency_valid", 32'(vld[0]), 32'd1);
        check("bin_latency_valid", 32'(vld[1]), 32'd1);
        nh = 32'(bsy[0]);
        nb = 32'(bsy[1]);
        for (int c = 0; c < 12; c++) begin
            @(posedge sysclk); #1;
            nh += 32'(bsy[0]);
            nb += 32'(bsy[1]);
        end
        check("hex_busy_cycles", nh, 32'd12);
        check("bin_busy_cycles", nb, 32'd5);
        set_small(1'b1);
        push_small(1'b1);
        cap = 1'b1;
        @(negedge sysclk);
        check("hex_done_cycle_no_overrun", 32'(ovr[0]), 32'd0);
        @(posedge sysclk); #1;
        cap = 1'b0;
        check("hex_b2b_started", 32'(bsy[0]), 32'd1);
        wait_idle("b2b");

        // Back-pressure: same symbols with random stalls.
        set_small(1'b0);
        push_small(1'b0);
        bp = 1'b1;
        pulse(1'b0);
        wait_idle("backpressure");
        bp = 1'b0;
        repeat (2) @(negedge sysclk);

        // Overrun at symbol 3 with different inputs.
        set_small(1'b0);
        push_small(1'b0);
        pulse(1'b0);
        repeat (3) begin @(posedge sysclk); #1; end
        hdr = 8'h5A; pay = 16'hBEEF; ftr = 8'h77;
        cap = 1'b1;
        @(negedge sysclk);
        check("hex_overrun_pulse", 32'(ovr[0]), 32'd1);
        check("bin_overrun_pulse", 32'(ovr[1]), 32'd1);
        @(posedge sysclk); #1;
        cap = 1'b0;
        @(negedge sysclk);
        check("hex_overrun_clear", 32'(ovr[0]), 32'd0);
        wait_idle("overrun");
        repeat (3) begin
            @(negedge sysclk);
            check("hex_no_second_frame", 32'(bsy[0]), 32'd0);
            check("bin_no_second_frame", 32'(bsy[1]), 32'd0);
        end

        // Reset at hex symbol 5, then a fresh frame.
        set_small(1'b0);
        push_small(1'b0);
        pulse(1'b0);
        repeat (4) @(posedge sysclk);
        #3;
        reset = 1'b1;
        #1;
        qh.delete();
        qb.delete();
        for (int k = 0; k < 2; k++) begin
            check({nm[k], "_midrst_data"},  32'(dat[k]), 32'd0);
            check({nm[k], "_midrst_valid"}, 32'(vld[k]), 32'd0);
            check({nm[k], "_midrst_busy"},  32'(bsy[k]), 32'd0);
            check({nm[k], "_midrst_done"},  32'(fd[k]),  32'd0);
        end
        repeat (2) @(posedge sysclk);
        #1;
        reset = 1'b0;
        set_small(1'b1);
        push_small(1'b1);
        pulse(1'b0);
        wait_idle("after_reset");

        // Default widths, hex, no checksum: 58 symbols; capture on the
        // last-transfer edge is an overrun.
        fv = {h3, p3, f3};
        for (int i = 0; i < 56; i++)
            q3.push_back({1'b0, asc(fv[223 - 4*i -: 4])});
        q3.push_back({1'b0, 8'h0D});
        q3.push_back({1'b1, 8'h0A});
        pulse(1'b1);
        repeat (57) begin @(posedge sysclk); #1; end
        cap3 = 1'b1;
        @(negedge sysclk);
        check("def_last_edge_overrun", 32'(ovr[2]), 32'd1);
        @(posedge sysclk); #1;
        cap3 = 1'b0;
        @(negedge sysclk);
        check("def_overrun_clear", 32'(ovr[2]), 32'd0);
        wait_idle("default");
        repeat (3) begin
            @(negedge sysclk);
            check("def_no_second_frame", 32'(bsy[2]), 32'd0);
        end
        check("def_symbol_count", xcount[2], 32'd58);
        check("def_frame_done_count", dcount[2], 32'd1);
        check("hex_frame_done_count", dcount[0], 32'd5);
        check("bin_frame_done_count", dcount[1], 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
